// File: rtl/edge_gen_pkg.sv
// ----------------------------------------------------------------------------
// edge_gen_pkg
// Shared types and helpers for the edge_level_gen block.
//   state_e         : FSM encoding, also exported on the top's debug port.
//   hold_cnt_width  : width of the hold down-counter, sized to hold
//                     max(min_high, min_low).
// ----------------------------------------------------------------------------
package edge_gen_pkg;

    typedef enum logic [1:0] {
        LOW_IDLE  = 2'd0,
        HIGH_HOLD = 2'd1,
        HIGH_IDLE = 2'd2,
        LOW_HOLD  = 2'd3
    } state_e;

    function automatic int hold_cnt_width(input int min_high, input int min_low);
        int m;
        m = (min_high > min_low) ? min_high : min_low;
        hold_cnt_width = (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/edge_hold_cnt.sv
// ----------------------------------------------------------------------------
// edge_hold_cnt
// Loadable down-counter that times the minimum high/low hold windows.
// The load takes priority; otherwise the count decrements while nonzero and
// rests at 0.
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset (count -> 0)
//   load_i      in   load load_val_i this cycle
//   load_val_i  in   value to load
//   cnt_o       out  current count
//   zero_o      out  count is 0 (hold window over)
// ----------------------------------------------------------------------------
module edge_hold_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load_i) begin
            cnt <= load_val_i;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign cnt_o  = cnt;
    assign zero_o = (cnt == '0);

endmodule

// File: rtl/edge_level_gen.sv
// ----------------------------------------------------------------------------
// edge_level_gen
// Turns rise/fall request strobes into a clean registered level with minimum
// high and low hold times. Edge pulses mark the first cycle of each new level
// so the downstream edge detector can be cross-checked.
//
// Request semantics: rise_req_i / fall_req_i are single-cycle strobes sampled
// on every rising clk edge. There is no back-pressure: a request is accepted,
// ignored as redundant, queued (optional), or discarded, and a discard is
// reported by a one-cycle drop_o pulse on the following cycle.
//
// Build option: define EDGE_LEVEL_GEN_QUEUE_EN to add a one-entry pending
// register that holds an opposite request made during the hold window and
// applies it in the first cycle the window is over.
//
// Parameters:
//   MIN_HIGH    min cycles level_o stays 1 after a rise (>=1)
//   MIN_LOW     min cycles level_o stays 0 after a fall (>=1)
//   INIT_LEVEL  level_o during and after reset
// Ports:
//   clk             in   clock, rising edge
//   reset           in   asynchronous active-high reset
//   rise_req_i      in   request level_o -> 1
//   fall_req_i      in   request level_o -> 0
//   level_o         out  generated level (registered)
//   rising_edge_o   out  pulse in the first cycle level_o reads 1
//   falling_edge_o  out  pulse in the first cycle level_o reads 0
//   busy_o          out  hold window active
//   drop_o          out  pulse the cycle after a request was discarded
//   state_o         out  FSM state (debug)
// ----------------------------------------------------------------------------
module edge_level_gen
    import edge_gen_pkg::*;
#(
    parameter int MIN_HIGH   = 4,
    parameter int MIN_LOW    = 4,
    parameter bit INIT_LEVEL = 1'b0
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   rise_req_i,
    input  logic   fall_req_i,
    output logic   level_o,
    output logic   rising_edge_o,
    output logic   falling_edge_o,
    output logic   busy_o,
    output logic   drop_o,
    output state_e state_o
);

    localparam int CW = hold_cnt_width(MIN_HIGH, MIN_LOW);

    localparam state_e INIT_STATE = INIT_LEVEL ? HIGH_IDLE : LOW_IDLE;
    localparam state_e RISE_STATE = (MIN_HIGH == 1) ? HIGH_IDLE : HIGH_HOLD;
    localparam state_e FALL_STATE = (MIN_LOW == 1) ? LOW_IDLE : LOW_HOLD;

    state_e        state;
    logic          level;
    logic          rising;
    logic          falling;
    logic          drop;

    logic [CW-1:0] cnt;
    logic          cnt_zero;
    logic [CW-1:0] load_val;

    logic          up_only;
    logic          down_only;
    logic          opposite;
    logic          redundant;
    logic          toggle;
    logic          drop_set;

`ifdef EDGE_LEVEL_GEN_QUEUE_EN
    // Only an opposite request is ever stored, so a single valid bit is
    // enough: its direction is always "toggle the current level".
    logic          pend_q;
    logic          pend_d;
`endif

    // Simultaneous rise and fall never counts as either direction.
    assign up_only   = rise_req_i & ~fall_req_i;
    assign down_only = fall_req_i & ~rise_req_i;
    assign opposite  = level ? down_only : up_only;
    assign redundant = level ? up_only : down_only;

    always_comb begin
        toggle   = 1'b0;
        drop_set = rise_req_i & fall_req_i;
`ifdef EDGE_LEVEL_GEN_QUEUE_EN
        pend_d   = pend_q;
`endif
        if (cnt_zero) begin
            toggle = opposite;
`ifdef EDGE_LEVEL_GEN_QUEUE_EN
            // A stored request fires now unless a same-level request in this
            // very cycle cancels it.
            if (pend_q) begin
                toggle = ~redundant;
                pend_d = 1'b0;
            end
`endif
        end else begin
`ifdef EDGE_LEVEL_GEN_QUEUE_EN
            if (redundant) begin
                pend_d = 1'b0;
            end else if (opposite) begin
                if (pend_q) begin
                    drop_set = 1'b1;
                end else begin
                    pend_d = 1'b1;
                end
            end
`else
            if (opposite) begin
                drop_set = 1'b1;
            end
`endif
        end
    end

    // Hold length of the level being entered, minus the first cycle itself.
    assign load_val = level ? CW'(MIN_LOW - 1) : CW'(MIN_HIGH - 1);

    edge_hold_cnt #(
        .W (CW)
    ) u_hold_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (toggle),
        .load_val_i (load_val),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= INIT_STATE;
            level   <= INIT_LEVEL;
            rising  <= 1'b0;
            falling <= 1'b0;
            drop    <= 1'b0;
        end else begin
            rising  <= toggle & ~level;
            falling <= toggle & level;
            drop    <= drop_set;
            if (toggle) begin
                level <= ~level;
                state <= level ? FALL_STATE : RISE_STATE;
            end else begin
                case (state)
                    // Leave the hold state in step with the counter reaching 0.
                    HIGH_HOLD: if (cnt == CW'(1)) state <= HIGH_IDLE;
                    LOW_HOLD:  if (cnt == CW'(1)) state <= LOW_IDLE;
                    default:   state <= state;
                endcase
            end
        end
    end

`ifdef EDGE_LEVEL_GEN_QUEUE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end
`endif

    assign level_o        = level;
    assign rising_edge_o  = rising;
    assign falling_edge_o = falling;
    assign busy_o         = ~cnt_zero;
    assign drop_o         = drop;
    assign state_o        = state;

endmodule

// File: tb/tb_edge_level_gen.sv
module tb_edge_level_gen;
    import edge_gen_pkg::*;

    localparam int MIN_HIGH   = 4;
    localparam int MIN_LOW    = 3;
    localparam bit INIT_LEVEL = 1'b0;
    localparam int RUN_CAP    = 1000;
`ifdef EDGE_LEVEL_GEN_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   reset;
    logic   rise_req;
    logic   fall_req;
    logic   level;
    logic   rising_edge;
    logic   falling_edge;
    logic   busy;
    logic   drop;
    state_e state;

    always #5 clk = ~clk;

    edge_level_gen #(
        .MIN_HIGH   (MIN_HIGH),
        .MIN_LOW    (MIN_LOW),
        .INIT_LEVEL (INIT_LEVEL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rise_req_i     (rise_req),
        .fall_req_i     (fall_req),
        .level_o        (level),
        .rising_edge_o  (rising_edge),
        .falling_edge_o (falling_edge),
        .busy_o         (busy),
        .drop_o         (drop),
        .state_o        (state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks how many cycles the current level has been visible; the hold
    // window is simply "run length shorter than the minimum for this level".
    bit m_level;
    int m_run;
    bit m_rise;
    bit m_fall;
    bit m_drop;
    bit m_pend;

    function automatic int min_for(input bit lv);
        return lv ? MIN_HIGH : MIN_LOW;
    endfunction

    function automatic bit m_busy();
        return m_run < min_for(m_level);
    endfunction

    task automatic model_reset();
        m_level = INIT_LEVEL;
        m_run   = RUN_CAP;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        m_drop  = 1'b0;
        m_pend  = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit f);
        bit b;
        bit want;
        bit same;
        bit change;
        bit dr;
        b      = m_busy();
        want   = m_level ? (f && !r) : (r && !f);
        same   = m_level ? (r && !f) : (f && !r);
        change = 1'b0;
        dr     = r && f;
        if (!b) begin
            if (QUEUE && m_pend) begin
                change = !same;
                m_pend = 1'b0;
            end else begin
                change = want;
            end
        end else if (want) begin
            if (QUEUE && !m_pend) m_pend = 1'b1;
            else dr = 1'b1;
        end else if (same && QUEUE) begin
            m_pend = 1'b0;
        end
        m_rise = change && !m_level;
        m_fall = change && m_level;
        m_drop = dr;
        if (change) begin
            m_level = !m_level;
            m_run   = 1;
        end else if (m_run < RUN_CAP) begin
            m_run++;
        end
    endtask

    function automatic state_e exp_state();
        if (m_level) return m_busy() ? HIGH_HOLD : HIGH_IDLE;
        return m_busy() ? LOW_HOLD : LOW_IDLE;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".level"}, 32'(level), 32'(m_level));
        check({tag, ".rise"},  32'(rising_edge), 32'(m_rise));
        check({tag, ".fall"},  32'(falling_edge), 32'(m_fall));
        check({tag, ".busy"},  32'(busy), 32'(m_busy()));
        check({tag, ".drop"},  32'(drop), 32'(m_drop));
        check({tag, ".state"}, 32'(state), 32'(exp_state()));
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1: drive inputs, let one edge pass, compare.
    task automatic step(input bit r, input bit f, input string tag);
        rise_req = r;
        fall_req = f;
        model_step(r, f);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b1;
        rise_req = 1'b0;
        fall_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // Directed: rise, early fall (refused or queued), legal fall.
        step(0, 0, "idle");
        step(1, 0, "rise");
        step(0, 0, "hold_h1");
        step(0, 1, "fall_busy");
        step(0, 0, "hold_h3");
        step(0, 1, "fall_ok");
        step(0, 0, "hold_l1");
        step(0, 0, "hold_l2");
        step(0, 0, "low_idle");
        step(1, 1, "both_low");
        step(0, 0, "after_both");
        step(1, 0, "rise2");
        repeat (4) step(0, 0, "wait_h");
        step(1, 0, "redundant_rise");
        step(0, 0, "after_red");

        // Back-to-back requests: each level run should equal its minimum.
        for (int i = 0; i < 8; i++) begin
            step(0, 1, "b2b_fall");
            step(0, 1, "b2b_fall");
            step(1, 0, "b2b_rise");
            step(1, 0, "b2b_rise");
            step(1, 0, "b2b_rise");
            step(0, 0, "b2b_gap");
        end

        // Randomized request traffic.
        for (int i = 0; i < 800; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2: step(1, 0, "rnd");
                3, 4, 5: step(0, 1, "rnd");
                6:       step(1, 1, "rnd");
                default: step(0, 0, "rnd");
            endcase
        end

        // Settle, then asynchronous reset in the middle of a high hold.
        repeat (6) step(0, 1, "settle");
        step(1, 0, "pre_reset_rise");
        step(0, 0, "pre_reset_hold");
        #3;
        reset = 1'b1;
        #1;
        check("async_rst.level", 32'(level), 32'(INIT_LEVEL));
        check("async_rst.busy",  32'(busy), 32'(0));
        check("async_rst.fall",  32'(falling_edge), 32'(0));
        check("async_rst.rise",  32'(rising_edge), 32'(0));
        model_reset();
        @(posedge clk);
        #1;
        check_all("in_reset");
        reset = 1'b0;
        step(0, 0, "post_reset");
        step(1, 0, "post_reset_rise");
        step(0, 0, "post_reset_hold");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout reached at %0t", $time);
        n_errors++;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
